// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if
//   Bundles the pipeline-side signals of the forwarding/hazard controller.
//   master: the pipeline (drives register addresses, write/load flags,
//           memory handshake, branch outcome; receives selects and controls).
//   slave : fwd_hazard_unit.
//   Ports (slave view):
//     in  rs_id, rs_ex        NUM_SRC*AW  source regs, operand k at [k*AW +: AW]
//     in  rd_ex/mem/wb        AW          producer destinations
//     in  regwrite_ex/mem/wb  1           producer writes a register
//     in  memread_ex/mem      1           producer is a load
//     in  mem_ready           1           load data returned this cycle
//     in  branch_taken        1           branch/jump in EX resolved taken
//     out fwd_sel             NUM_SRC*2   00 regfile, 10 EX/MEM, 01 MEM/WB, 11 WB
//     out stall_front, bubble_idex, hold_back, flush_front, mem_timeout
//     out lu_stall_cnt, mem_wait_cnt  CNT_W saturating counters
interface fwd_hazard_unit_if #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC*AW-1:0] rs_id;
    logic [NUM_SRC*AW-1:0] rs_ex;
    logic [AW-1:0]         rd_ex;
    logic                  regwrite_ex;
    logic                  memread_ex;
    logic [AW-1:0]         rd_mem;
    logic                  regwrite_mem;
    logic                  memread_mem;
    logic [AW-1:0]         rd_wb;
    logic                  regwrite_wb;
    logic                  mem_ready;
    logic                  branch_taken;
    logic [NUM_SRC*2-1:0]  fwd_sel;
    logic                  stall_front;
    logic                  bubble_idex;
    logic                  hold_back;
    logic                  flush_front;
    logic                  mem_timeout;
    logic [CNT_W-1:0]      lu_stall_cnt;
    logic [CNT_W-1:0]      mem_wait_cnt;

    modport master (
        output rs_id, rs_ex, rd_ex, regwrite_ex, memread_ex,
               rd_mem, regwrite_mem, memread_mem, rd_wb, regwrite_wb,
               mem_ready, branch_taken,
        input  fwd_sel, stall_front, bubble_idex, hold_back, flush_front,
               mem_timeout, lu_stall_cnt, mem_wait_cnt
    );

    modport slave (
        input  rs_id, rs_ex, rd_ex, regwrite_ex, memread_ex,
               rd_mem, regwrite_mem, memread_mem, rd_wb, regwrite_wb,
               mem_ready, branch_taken,
        output fwd_sel, stall_front, bubble_idex, hold_back, flush_front,
               mem_timeout, lu_stall_cnt, mem_wait_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Forwarding and hazard controller for a 5-stage RISC-V pipeline:
//   per-operand bypass selects for EX, load-use stall/bubble, branch flush,
//   and a memory-wait freeze guarded by a watchdog FSM.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-low reset; all combinational outputs are 0
//            while it is low
//     bus    fwd_hazard_unit_if.slave (see the interface file)
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   ST_RUN      | no outstanding memory wait
//   ST_MEM_WAIT | load in MEM still waiting for data; pipeline frozen
//   ST_TIMEOUT  | wait exceeded MAX_WAIT; frozen until reset
module fwd_hazard_unit #(
    parameter int NUM_SRC   = 2,
    parameter int AW        = 5,
    parameter int WB_BYPASS = 0,
    parameter int MAX_WAIT  = 16,
    parameter int CNT_W     = 16
) (
    input  logic           clk,
    input  logic           reset,
    fwd_hazard_unit_if.slave bus
);

    localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_TIMEOUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_q, wait_d;     // wait cycles still allowed, down-counter
    logic [CNT_W-1:0] lu_cnt_q, mem_cnt_q;

    logic                 wait_req;
    logic                 freeze;
    logic                 lu_hit;
    logic                 lu_eff;
    logic [NUM_SRC*2-1:0] fwd_c;

    assign wait_req = bus.memread_mem & ~bus.mem_ready;

    // First match wins: EX/MEM, then MEM/WB, then the WB write.
    always_comb begin
        fwd_c = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.regwrite_ex && (bus.rd_ex != '0) &&
                (bus.rd_ex == bus.rs_ex[k*AW +: AW])) begin
                fwd_c[k*2 +: 2] = 2'b10;
            end else if (bus.regwrite_mem && (bus.rd_mem != '0) &&
                         (bus.rd_mem == bus.rs_ex[k*AW +: AW])) begin
                fwd_c[k*2 +: 2] = 2'b01;
            end else if ((WB_BYPASS != 0) && bus.regwrite_wb && (bus.rd_wb != '0) &&
                         (bus.rd_wb == bus.rs_ex[k*AW +: AW])) begin
                fwd_c[k*2 +: 2] = 2'b11;
            end
        end
    end

    always_comb begin
        lu_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.rd_ex == bus.rs_id[k*AW +: AW]) lu_hit = 1'b1;
        end
    end

    // A taken branch squashes the dependent instruction, so no stall is needed;
    // a freeze masks both since the held inputs re-evaluate once unfrozen.
    assign lu_eff = bus.memread_ex & bus.regwrite_ex & (bus.rd_ex != '0) & lu_hit
                    & ~bus.branch_taken & ~freeze;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        freeze  = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (wait_req) begin
                    freeze = 1'b1;
                    wait_d = WCW'(MAX_WAIT - 1);
                    state_d = (MAX_WAIT <= 1) ? ST_TIMEOUT : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_req) begin
                    freeze = 1'b1;
                    if (wait_q <= WCW'(1)) begin
                        state_d = ST_TIMEOUT;
                    end else begin
                        wait_d = wait_q - WCW'(1);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_TIMEOUT: begin
                freeze = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            wait_q    <= '0;
            lu_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (lu_eff && (lu_cnt_q != '1)) lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            if (freeze && (mem_cnt_q != '1)) mem_cnt_q <= mem_cnt_q + CNT_W'(1);
        end
    end

    assign bus.fwd_sel      = reset ? fwd_c : '0;
    assign bus.stall_front  = reset & (freeze | lu_eff);
    assign bus.bubble_idex  = reset & lu_eff;
    assign bus.hold_back    = reset & freeze;
    assign bus.flush_front  = reset & bus.branch_taken & ~freeze;
    assign bus.mem_timeout  = reset & (state_q == ST_TIMEOUT);
    assign bus.lu_stall_cnt = lu_cnt_q;
    assign bus.mem_wait_cnt = mem_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit
//   Directed test of fwd_hazard_unit with WB_BYPASS=1, MAX_WAIT=4 and 2-bit
//   counters so saturation is reachable in a few cycles.
module tb_fwd_hazard_unit;

    localparam int NUM_SRC = 2;
    localparam int AW      = 5;
    localparam int CNT_W   = 2;

    logic clk;
    logic reset;
    int   checks = 0;
    int   fails  = 0;

    fwd_hazard_unit_if #(.NUM_SRC(NUM_SRC), .AW(AW), .CNT_W(CNT_W)) bus ();

    fwd_hazard_unit #(
        .NUM_SRC(NUM_SRC), .AW(AW), .WB_BYPASS(1), .MAX_WAIT(4), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        bus.rs_id = '0;        bus.rs_ex = '0;
        bus.rd_ex = '0;        bus.regwrite_ex = 1'b0;  bus.memread_ex = 1'b0;
        bus.rd_mem = '0;       bus.regwrite_mem = 1'b0; bus.memread_mem = 1'b0;
        bus.rd_wb = '0;        bus.regwrite_wb = 1'b0;
        bus.mem_ready = 1'b0;  bus.branch_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctl(input string tag, input logic st, input logic bb,
                       input logic hb, input logic fl);
        chk({tag, "_stall"},  bus.stall_front, st);
        chk({tag, "_bubble"}, bus.bubble_idex, bb);
        chk({tag, "_hold"},   bus.hold_back,   hb);
        chk({tag, "_flush"},  bus.flush_front, fl);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        clear();
        // Active inputs while in reset: every output must still be 0.
        bus.rd_ex = 5'd5; bus.regwrite_ex = 1'b1; bus.rs_ex = {5'd6, 5'd5};
        bus.branch_taken = 1'b1; bus.memread_mem = 1'b1;
        #3;
        chk("rst_fwd", bus.fwd_sel, 4'b0000);
        ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_tmo", bus.mem_timeout, 1'b0);
        chk("rst_lucnt", bus.lu_stall_cnt, 2'd0);
        chk("rst_mwcnt", bus.mem_wait_cnt, 2'd0);
        clear();
        tick();
        reset = 1'b1;
        tick();

        // Forwarding priority and sources.
        bus.rs_ex = {5'd6, 5'd5};
        bus.rd_ex = 5'd5; bus.regwrite_ex = 1'b1;
        #1 chk("fwd_exmem", bus.fwd_sel, 4'b0010);
        bus.rd_mem = 5'd5; bus.regwrite_mem = 1'b1;
        #1 chk("fwd_exmem_prio", bus.fwd_sel, 4'b0010);
        bus.rd_mem = 5'd6;
        #1 chk("fwd_both", bus.fwd_sel, 4'b0110);
        bus.regwrite_ex = 1'b0; bus.rd_wb = 5'd5; bus.regwrite_wb = 1'b1;
        #1 chk("fwd_wb", bus.fwd_sel, 4'b0111);
        bus.rd_ex = 5'd6; bus.regwrite_ex = 1'b1; bus.regwrite_mem = 1'b0;
        #1 chk("fwd_wb_ex", bus.fwd_sel, 4'b1011);
        ctl("fwd", 1'b0, 1'b0, 1'b0, 1'b0);
        clear();

        // x0 never matches.
        bus.rd_ex = '0; bus.rd_mem = '0; bus.rd_wb = '0;
        bus.regwrite_ex = 1'b1; bus.regwrite_mem = 1'b1; bus.regwrite_wb = 1'b1;
        bus.memread_ex = 1'b1;
        #1 chk("x0_fwd", bus.fwd_sel, 4'b0000);
        ctl("x0", 1'b0, 1'b0, 1'b0, 1'b0);
        clear();

        // A load in EX/MEM matching rs_ex still selects 10.
        bus.rd_ex = 5'd9; bus.regwrite_ex = 1'b1; bus.memread_ex = 1'b1;
        bus.rs_ex = {5'd1, 5'd9}; bus.rs_id = {5'd2, 5'd3};
        #1 chk("ldfwd_fwd", bus.fwd_sel, 4'b0010);
        ctl("ldfwd", 1'b0, 1'b0, 1'b0, 1'b0);
        clear();
        tick();

        // Load-use: lw x7 in EX, consumer reads x7 as operand 1.
        bus.rd_ex = 5'd7; bus.regwrite_ex = 1'b1; bus.memread_ex = 1'b1;
        bus.rs_id = {5'd7, 5'd1};
        #1 ctl("lu", 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("lu_cnt1", bus.lu_stall_cnt, 2'd1);
        clear();
        bus.rd_mem = 5'd7; bus.regwrite_mem = 1'b1; bus.memread_mem = 1'b1;
        bus.mem_ready = 1'b1; bus.rs_id = {5'd7, 5'd1};
        #1 ctl("lu_next", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lu_cnt_hold", bus.lu_stall_cnt, 2'd1);
        chk("lu_mwcnt", bus.mem_wait_cnt, 2'd0);
        clear();

        // Branch taken with load-use: flush wins.
        bus.rd_ex = 5'd7; bus.regwrite_ex = 1'b1; bus.memread_ex = 1'b1;
        bus.rs_id = {5'd1, 5'd7}; bus.branch_taken = 1'b1;
        #1 ctl("br_lu", 1'b0, 1'b0, 1'b0, 1'b1);
        clear();

        // mem_ready without a load is ignored.
        bus.mem_ready = 1'b1;
        #1 ctl("rdy_only", 1'b0, 1'b0, 1'b0, 1'b0);
        clear();
        tick();

        // Memory wait of 3 cycles with branch and load-use pending.
        bus.memread_mem = 1'b1; bus.mem_ready = 1'b0;
        bus.rd_ex = 5'd7; bus.regwrite_ex = 1'b1; bus.memread_ex = 1'b1;
        bus.rs_id = {5'd1, 5'd7}; bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 ctl("wait", 1'b1, 1'b0, 1'b1, 1'b0);
            chk("wait_tmo", bus.mem_timeout, 1'b0);
            tick();
        end
        bus.mem_ready = 1'b1;
        #1 ctl("wait_done", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("wait_mwcnt", bus.mem_wait_cnt, 2'd3);
        clear();
        // Back in RUN: a ready load does not freeze.
        bus.memread_mem = 1'b1; bus.mem_ready = 1'b1;
        #1 ctl("wait_run", 1'b0, 1'b0, 1'b0, 1'b0);
        clear();
        do_reset();

        // Timeout after 4 wait cycles; counter saturates at 3.
        bus.memread_mem = 1'b1; bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("to_hold", bus.hold_back, 1'b1);
            chk("to_tmo_pre", bus.mem_timeout, 1'b0);
            tick();
            if (i == 2) chk("to_mwcnt3", bus.mem_wait_cnt, 2'd3);
        end
        chk("to_tmo", bus.mem_timeout, 1'b1);
        chk("to_mwcnt_sat", bus.mem_wait_cnt, 2'd3);
        bus.mem_ready = 1'b1;
        #1 ctl("to_stuck", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("to_stuck_tmo", bus.mem_timeout, 1'b1);
        chk("to_stuck_hold", bus.hold_back, 1'b1);

        // Asynchronous reset mid-cycle clears outputs immediately.
        bus.branch_taken = 1'b1; bus.rs_ex = {5'd0, 5'd4};
        bus.rd_ex = 5'd4; bus.regwrite_ex = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("arst_tmo", bus.mem_timeout, 1'b0);
        ctl("arst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("arst_fwd", bus.fwd_sel, 4'b0000);
        chk("arst_mwcnt", bus.mem_wait_cnt, 2'd0);
        chk("arst_lucnt", bus.lu_stall_cnt, 2'd0);
        clear();
        #2 reset = 1'b1;
        tick();

        // After reset the FSM is in RUN: a one-cycle wait releases.
        bus.memread_mem = 1'b1; bus.mem_ready = 1'b0;
        #1 chk("post_hold", bus.hold_back, 1'b1);
        tick();
        bus.mem_ready = 1'b1;
        #1 chk("post_release", bus.hold_back, 1'b0);
        chk("post_tmo", bus.mem_timeout, 1'b0);
        tick();
        chk("post_mwcnt", bus.mem_wait_cnt, 2'd1);
        clear();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
